// File: rtl/stream_demux.sv
// stream_demux: splits one tagged beat stream into STREAM_COUNT output streams.
// The first beat of each packet picks the output from s_id_i. The rest of the
// packet follows the same output, whatever id its beats carry. A packet whose
// first beat carries an out-of-range id is discarded whole and counted.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   s_*_i / s_ready_o input stream (data, qos, id, last, valid / ready)
//   m_*_o / m_ready_i per-output streams, one register slice each
//   drop_cnt_o        saturating count of dropped packets

// One output register slice. It can load when it is empty or being drained
// in the same cycle. Because of that, held data never changes under stall.
module stream_demux_slot #(
  parameter int DW = 8,
  parameter int QW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic [DW-1:0] data_i,
  input  logic [QW-1:0] qos_i,
  input  logic          last_i,
  input  logic          ready_i,
  output logic          free_o,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  output logic [QW-1:0] qos_o,
  output logic          last_o
);
  logic          valid_q;
  logic [DW-1:0] data_q;
  logic [QW-1:0] qos_q;
  logic          last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      qos_q   <= '0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      qos_q   <= qos_i;
      last_q  <= last_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign free_o  = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign qos_o   = qos_q;
  assign last_o  = last_q;
endmodule

module stream_demux #(
  parameter int T_DATA_WIDTH = 8,
  parameter int T_QOS__WIDTH = 4,
  parameter int STREAM_COUNT = 2,
  parameter int CNT_WIDTH    = 16,
  localparam int T_ID___WIDTH = (STREAM_COUNT > 1) ? $clog2(STREAM_COUNT) : 1
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic [T_DATA_WIDTH-1:0]                    s_data_i,
  input  logic [T_QOS__WIDTH-1:0]                    s_qos_i,
  input  logic [T_ID___WIDTH-1:0]                    s_id_i,
  input  logic                                       s_last_i,
  input  logic                                       s_valid_i,
  output logic                                       s_ready_o,
  output logic [STREAM_COUNT-1:0][T_DATA_WIDTH-1:0]  m_data_o,
  output logic [STREAM_COUNT-1:0][T_QOS__WIDTH-1:0]  m_qos_o,
  output logic [STREAM_COUNT-1:0]                    m_last_o,
  output logic [STREAM_COUNT-1:0]                    m_valid_o,
  input  logic [STREAM_COUNT-1:0]                    m_ready_i,
  output logic [CNT_WIDTH-1:0]                       drop_cnt_o
);
  typedef enum logic [1:0] {IDLE, PKT, DROP} state_e;

  state_e                  state_q;
  logic [T_ID___WIDTH-1:0] lock_id_q;
  logic [CNT_WIDTH-1:0]    drop_cnt_q;

  logic                    id_ok;
  logic [T_ID___WIDTH-1:0] tgt;
  logic                    tgt_vld;
  logic [STREAM_COUNT-1:0] sel;
  logic [STREAM_COUNT-1:0] free;
  logic [STREAM_COUNT-1:0] load;
  logic                    accept;

  // Out-of-range ids only exist for a non-power-of-2 STREAM_COUNT.
  assign id_ok   = 32'(s_id_i) < STREAM_COUNT;
  assign tgt     = (state_q == PKT) ? lock_id_q : s_id_i;
  assign tgt_vld = (state_q == PKT) || ((state_q == IDLE) && id_ok);

  // A one-hot lane select avoids indexing the outputs with an out-of-range id.
  // With no target (drop), the input is always accepted so the beat can be discarded.
  assign s_ready_o = !tgt_vld || |(sel & free);
  assign accept    = s_valid_i && s_ready_o;

  for (genvar i = 0; i < STREAM_COUNT; i++) begin : g_lane
    assign sel[i]  = tgt_vld && (tgt == T_ID___WIDTH'(i));
    assign load[i] = accept && sel[i];

    stream_demux_slot #(.DW(T_DATA_WIDTH), .QW(T_QOS__WIDTH)) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .load_i  (load[i]),
      .data_i  (s_data_i),
      .qos_i   (s_qos_i),
      .last_i  (s_last_i),
      .ready_i (m_ready_i[i]),
      .free_o  (free[i]),
      .valid_o (m_valid_o[i]),
      .data_o  (m_data_o[i]),
      .qos_o   (m_qos_o[i]),
      .last_o  (m_last_o[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lock_id_q  <= '0;
      drop_cnt_q <= '0;
    end else if (accept) begin
      case (state_q)
        IDLE: begin
          if (id_ok) begin
            if (!s_last_i) begin
              state_q   <= PKT;
              lock_id_q <= s_id_i;
            end
          end else begin
            if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
            if (!s_last_i) state_q <= DROP;
          end
        end
        PKT, DROP: if (s_last_i) state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
    end
  end

  assign drop_cnt_o = drop_cnt_q;
endmodule

// File: tb/tb_stream_demux.sv
// Bench for stream_demux. Two instances are used:
//   u4: 4 outputs, 16-bit counter (routing, lock, backpressure, reset)
//   u3: 3 outputs, 2-bit counter (drop and saturation)
// Stimulus pushes the expected beats into per-output queues. Monitors pop and
// compare them whenever an output transfers.
module tb_stream_demux;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // u4 signals
  logic [7:0]      s4_data = '0;
  logic [3:0]      s4_qos = '0;
  logic [1:0]      s4_id = '0;
  logic            s4_last = 1'b0, s4_valid = 1'b0, s4_ready;
  logic [3:0][7:0] m4_data;
  logic [3:0][3:0] m4_qos;
  logic [3:0]      m4_last, m4_valid;
  logic [3:0]      m4_ready = '1;
  logic [15:0]     drop4;

  // u3 signals
  logic [7:0]      s3_data = '0;
  logic [3:0]      s3_qos = '0;
  logic [1:0]      s3_id = '0;
  logic            s3_last = 1'b0, s3_valid = 1'b0, s3_ready;
  logic [2:0][7:0] m3_data;
  logic [2:0][3:0] m3_qos;
  logic [2:0]      m3_last, m3_valid;
  logic [2:0]      m3_ready = '1;
  logic [1:0]      drop3;

  stream_demux #(.T_DATA_WIDTH(8), .T_QOS__WIDTH(4), .STREAM_COUNT(4), .CNT_WIDTH(16)) u4 (
    .clk(clk), .rst_n(rst_n), .s_data_i(s4_data), .s_qos_i(s4_qos), .s_id_i(s4_id),
    .s_last_i(s4_last), .s_valid_i(s4_valid), .s_ready_o(s4_ready), .m_data_o(m4_data),
    .m_qos_o(m4_qos), .m_last_o(m4_last), .m_valid_o(m4_valid), .m_ready_i(m4_ready),
    .drop_cnt_o(drop4));

  stream_demux #(.T_DATA_WIDTH(8), .T_QOS__WIDTH(4), .STREAM_COUNT(3), .CNT_WIDTH(2)) u3 (
    .clk(clk), .rst_n(rst_n), .s_data_i(s3_data), .s_qos_i(s3_qos), .s_id_i(s3_id),
    .s_last_i(s3_last), .s_valid_i(s3_valid), .s_ready_o(s3_ready), .m_data_o(m3_data),
    .m_qos_o(m3_qos), .m_last_o(m3_last), .m_valid_o(m3_valid), .m_ready_i(m3_ready),
    .drop_cnt_o(drop3));

  // expected beat = {last, qos, data}
  logic [12:0] exp4 [4][$];
  logic [12:0] exp3 [3][$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: every transfer must match the head of its output's queue.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (m4_valid[i] && m4_ready[i]) begin
          if (exp4[i].size() == 0) chk($sformatf("u4 unexpected beat out%0d", i), 32'(m4_data[i]), 32'hdead);
          else chk($sformatf("u4 out%0d beat", i), 32'({m4_last[i], m4_qos[i], m4_data[i]}), 32'(exp4[i].pop_front()));
        end
      end
      for (int i = 0; i < 3; i++) begin
        if (m3_valid[i] && m3_ready[i]) begin
          if (exp3[i].size() == 0) chk($sformatf("u3 unexpected beat out%0d", i), 32'(m3_data[i]), 32'hdead);
          else chk($sformatf("u3 out%0d beat", i), 32'({m3_last[i], m3_qos[i], m3_data[i]}), 32'(exp3[i].pop_front()));
        end
      end
    end
  end

  // Called at posedge+1. Returns at posedge+1 after acceptance.
  // exp_o < 0: nothing expected at any output.
  task automatic send4(input int exp_o, input logic [1:0] id, input logic [7:0] d,
                       input logic [3:0] q, input logic l);
    int n = 0;
    s4_valid = 1'b1; s4_id = id; s4_data = d; s4_qos = q; s4_last = l;
    @(negedge clk);
    while (!s4_ready && n < 50) begin n++; @(negedge clk); end
    if (!s4_ready) chk("u4 send timeout", 32'(s4_ready), 32'd1);
    @(posedge clk); #1;
    s4_valid = 1'b0;
    if (exp_o >= 0) exp4[exp_o].push_back({l, q, d});
  endtask

  // chk_rdy: the beat must be accepted at once (dropped beats never stall).
  task automatic send3(input int exp_o, input bit chk_rdy, input logic [1:0] id,
                       input logic [7:0] d, input logic [3:0] q, input logic l);
    int n = 0;
    s3_valid = 1'b1; s3_id = id; s3_data = d; s3_qos = q; s3_last = l;
    @(negedge clk);
    if (chk_rdy) chk("u3 drop beat ready", 32'(s3_ready), 32'd1);
    while (!s3_ready && n < 50) begin n++; @(negedge clk); end
    if (!s3_ready) chk("u3 send timeout", 32'(s3_ready), 32'd1);
    @(posedge clk); #1;
    s3_valid = 1'b0;
    if (exp_o >= 0) exp3[exp_o].push_back({l, q, d});
  endtask

  initial begin
    // ---- reset state
    repeat (2) @(negedge clk);
    chk("reset m_valid", 32'(m4_valid), 32'h0);
    chk("reset m_data", 32'(m4_data), 32'h0);
    chk("reset m_qos/last", 32'({m4_qos, m4_last}), 32'h0);
    chk("reset s_ready", 32'(s4_ready), 32'd1);
    chk("reset drop_cnt", 32'(drop4), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // ---- single-beat routing
    send4(2, 2'd2, 8'hA5, 4'd3, 1'b1);
    @(negedge clk);
    chk("single m_valid", 32'(m4_valid), 32'h4);
    chk("single data/qos/last", 32'({m4_last[2], m4_qos[2], m4_data[2]}), 32'h13A5);
    @(posedge clk); #1;

    // ---- packet lock: later ids ignored
    send4(1, 2'd1, 8'h11, 4'd1, 1'b0);
    send4(1, 2'd3, 8'h12, 4'd2, 1'b0);
    send4(1, 2'd0, 8'h13, 4'd3, 1'b1);
    send4(3, 2'd3, 8'h14, 4'd5, 1'b1);
    repeat (2) @(posedge clk); #1;

    // ---- backpressure on output 0
    m4_ready[0] = 1'b0;
    send4(0, 2'd0, 8'h21, 4'd1, 1'b1);
    send4(1, 2'd1, 8'h31, 4'd2, 1'b1);   // other output unaffected
    @(negedge clk);
    chk("bp other output delivered", 32'(m4_valid), 32'h3);
    @(posedge clk); #1;
    s4_valid = 1'b1; s4_id = 2'd0; s4_data = 8'h22; s4_qos = 4'd4; s4_last = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("bp s_ready low", 32'(s4_ready), 32'd0);
      chk("bp held data", 32'({m4_valid[0], m4_data[0]}), 32'h121);
      @(posedge clk); #1;
    end
    m4_ready[0] = 1'b1;
    #1 chk("bp s_ready follows m_ready", 32'(s4_ready), 32'd1);
    @(posedge clk); #1;
    s4_valid = 1'b0;
    exp4[0].push_back({1'b1, 4'd4, 8'h22});
    @(negedge clk);
    chk("bp second beat next cycle", 32'({m4_valid[0], m4_data[0]}), 32'h122);
    @(posedge clk); #1;

    // ---- drop on u3 (id 3 invalid); later beats carry varied ids
    send3(-1, 1'b1, 2'd3, 8'h40, 4'd0, 1'b0);
    send3(-1, 1'b1, 2'd0, 8'h41, 4'd0, 1'b0);
    send3(-1, 1'b1, 2'd1, 8'h42, 4'd0, 1'b0);
    send3(-1, 1'b1, 2'd3, 8'h43, 4'd0, 1'b1);
    chk("drop cnt after pkt 1", 32'(drop3), 32'd1);
    send3(-1, 1'b1, 2'd3, 8'h44, 4'd0, 1'b1);
    chk("drop cnt after pkt 2", 32'(drop3), 32'd2);
    chk("drop no valid", 32'(m3_valid), 32'h0);
    send3(0, 1'b0, 2'd0, 8'h77, 4'd6, 1'b1);
    @(negedge clk);
    chk("after drop routes id0", 32'(m3_valid), 32'h1);
    @(posedge clk); #1;

    // ---- async reset mid-packet with output 1 full
    m4_ready[1] = 1'b0;
    send4(-1, 2'd1, 8'h51, 4'd1, 1'b0);
    chk("pre-reset out1 full", 32'(m4_valid), 32'h2);
    #2 rst_n = 1'b0;
    #1 chk("async reset m_valid", 32'(m4_valid), 32'h0);
    chk("async reset drop_cnt", 32'(drop3), 32'd0);
    m4_ready = '1;
    @(posedge clk); #1 rst_n = 1'b1;
    send4(0, 2'd0, 8'h55, 4'd2, 1'b1);
    @(negedge clk);
    chk("post-reset routes id0", 32'(m4_valid), 32'h1);
    @(posedge clk); #1;

    // ---- saturation of the 2-bit counter
    for (int k = 1; k <= 5; k++) begin
      send3(-1, 1'b1, 2'd3, 8'(k), 4'd0, 1'b1);
      chk($sformatf("sat drop_cnt after %0d", k), 32'(drop3), (k < 3) ? 32'(k) : 32'd3);
    end

    repeat (4) @(posedge clk);
    for (int i = 0; i < 4; i++) chk($sformatf("u4 out%0d queue empty", i), 32'(exp4[i].size()), 32'd0);
    for (int i = 0; i < 3; i++) chk($sformatf("u3 out%0d queue empty", i), 32'(exp3[i].size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
